pixel_plot_writer: RTL and testbench
====================================

PIXEL_PLOT_WRITER -- requirements
Module: pixel_plot_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, plot-request buffer entries (power of 2, 2..16).
REQ-002 SHALL have parameter COLOUR_W, default 3, pixel colour width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  drawing block presents a plot point.
REQ-006 SHALL have port in_ready  output  1  writer accepts the point this cycle.
REQ-007 SHALL have port in_x  input  10  X coordinate, 0..639.
REQ-008 SHALL have port in_y  input  9  Y coordinate, 0..479.
REQ-009 SHALL have port in_colour  input  COLOUR_W  pixel colour.
REQ-010 SHALL have port flush  input  1  drawing sequence finished; request completion report.
REQ-011 SHALL have port flush_done  output  1  one-cycle pulse: all accepted points written.
REQ-012 SHALL have port mem_addr  output  19  framebuffer word address.
REQ-013 SHALL have port mem_data  output  COLOUR_W  framebuffer write data.
REQ-014 SHALL have port mem_we  output  1  write request to framebuffer.
REQ-015 SHALL have port mem_ready  input  1  framebuffer completes the write at this edge.
REQ-016 SHALL have port clip_count  output  8  count of discarded out-of-range points.

Function
REQ-017 Point accepted on rising edge where in_valid && in_ready; in_ready SHALL equal !fifo_full (no same-cycle bypass when full).
REQ-018 Accepted points SHALL be written to memory in acceptance order, none dropped or duplicated (clipping excepted, REQ-031).
REQ-019 mem_addr SHALL equal in_y*640 + in_x, computed as (y<<9)+(y<<7)+x, 19-bit unsigned; max 307199.
REQ-020 FSM states: IDLE, WRITE; IDLE->WRITE when FIFO non-empty (pop head into address register, mem_we=1 next cycle).
REQ-021 In WRITE, mem_addr/mem_data/mem_we SHALL hold stable until an edge with mem_ready=1.
REQ-022 On write completion: FIFO non-empty -> pop next head, stay WRITE (back-to-back, mem_we stays 1); else -> IDLE, mem_we=0.
REQ-023 Latency: point accepted into empty FIFO in IDLE at edge N SHALL present mem_we=1 after edge N+1.
REQ-024 Simultaneous accept and pop SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 flush sampled high SHALL set a sticky pending flag; held/repeated flush while pending has no extra effect.
REQ-026 flush_done SHALL pulse for exactly one cycle on the first edge where pending=1, FIFO empty, state IDLE; pending clears same edge.
REQ-027 flush with nothing outstanding SHALL yield flush_done one cycle after flush is sampled.
REQ-028 clip_count SHALL saturate at 255.

Reset
REQ-029 resetn=0 SHALL immediately clear FIFO pointers/occupancy, flush pending, clip_count; force state IDLE, mem_we=0, mem_addr=0, mem_data=0, flush_done=0, in_ready=0 while asserted.
REQ-030 Reset mid-write SHALL abandon the in-flight write and all buffered points; in_ready=1 on first cycle after deassertion.

Configuration
REQ-031 With PLOT_CLIP_EN defined: points with in_x>639 or in_y>479 SHALL be accepted (in_ready unaffected) but not enqueued, and clip_count incremented.
REQ-032 Without PLOT_CLIP_EN: no range check; all points enqueued, address truncated to 19 bits; clip_count tied to 0.

Verification
REQ-033 Single point x=5,y=2,colour=3, mem_ready=1 -> mem_we one cycle, mem_addr=1285, mem_data=3.
REQ-034 Burst of 6 points, mem_ready=0 for 20 cycles -> in_ready=0 after 4 buffered+1 in flight; on release six writes in order, no loss.
REQ-035 x=639,y=479 -> mem_addr=307199; x=0,y=0 -> mem_addr=0.
REQ-036 3 points then flush, mem_ready toggling 1-of-3 cycles -> flush_done single pulse exactly one cycle after final write completes.
REQ-037 With PLOT_CLIP_EN, x=700,y=10 -> no mem_we, clip_count=1; 300 such points -> clip_count=255.
REQ-038 resetn asserted during WRITE with 3 queued -> mem_we=0 immediately; after release no stale writes, flush gives flush_done next cycle.

Source files
------------

// File: rtl/pixel_plot_writer.sv
// Purpose:      buffers plot points from a drawing block and writes them to a framebuffer as y*640+x.
// Latency:      point accepted into an empty queue while idle at edge N shows mem_we=1 after edge N+1.
// Backpressure: in_ready = !queue_full; each write holds addr/data/we until mem_ready, then the next point follows back-to-back.
//
// Ports: clk, resetn (async active-low); in_valid/in_ready/in_x/in_y/in_colour plot stream;
//        flush/flush_done completion handshake; mem_addr/mem_data/mem_we/mem_ready framebuffer
//        write port; clip_count = saturating count of discarded off-screen points.
// Optional feature: define PLOT_CLIP_EN to discard points outside 640x480 and count them.

module plot_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = store[rd_ptr];

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= din;
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module pixel_plot_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int COLOUR_W   = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [9:0]          in_x,
  input  logic [8:0]          in_y,
  input  logic [COLOUR_W-1:0] in_colour,
  input  logic                flush,
  output logic                flush_done,
  output logic [18:0]         mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_we,
  input  logic                mem_ready,
  output logic [7:0]          clip_count
);
  localparam int ENT_W = 19 + COLOUR_W;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t             state;
  logic               flush_pend;
  logic [18:0]        in_addr;
  logic [18:0]        y_ext;
  logic               accept;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENT_W-1:0]   fifo_dout;

  // y*640 = y*512 + y*128; the address is formed at entry so the queue holds it directly.
  assign y_ext   = {10'd0, in_y};
  assign in_addr = (y_ext << 9) + (y_ext << 7) + {9'd0, in_x};

  // Gating with resetn keeps in_ready low for the whole time reset is held.
  assign in_ready = resetn && !fifo_full;
  assign accept   = in_valid && in_ready;

`ifdef PLOT_CLIP_EN
  logic in_range;
  assign in_range = (in_x <= 10'd639) && (in_y <= 9'd479);
  assign push     = accept && in_range;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clip_count <= 8'd0;
    end else if (accept && !in_range && (clip_count != 8'hFF)) begin
      clip_count <= clip_count + 8'd1;
    end
  end
`else
  assign push       = accept;
  assign clip_count = 8'd0;
`endif

  // The head is taken whenever the write port is free: idle, or the current write completes now.
  assign pop = !fifo_empty && ((state == IDLE) || mem_ready);

  plot_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    ({in_addr, in_colour}),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= 19'd0;
      mem_data   <= '0;
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            {mem_addr, mem_data} <= fifo_dout;
            mem_we               <= 1'b1;
            state                <= WRITE;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            if (!fifo_empty) begin
              {mem_addr, mem_data} <= fifo_dout;
            end else begin
              mem_we <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A flush seen while one is already pending is absorbed, including on the edge it completes.
      flush_done <= 1'b0;
      if (flush_pend) begin
        if (fifo_empty && (state == IDLE)) begin
          flush_done <= 1'b1;
          flush_pend <= 1'b0;
        end
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pixel_plot_writer.sv
module tb_pixel_plot_writer;
  localparam int CW = 3;

  logic          clk;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [9:0]    in_x;
  logic [8:0]    in_y;
  logic [CW-1:0] in_colour;
  logic          flush;
  logic          flush_done;
  logic [18:0]   mem_addr;
  logic [CW-1:0] mem_data;
  logic          mem_we;
  logic          mem_ready;
  logic [7:0]    clip_count;

  int checks = 0;
  int errors = 0;

  logic [18:0]   wa [$];
  logic [CW-1:0] wd [$];

  pixel_plot_writer #(
    .FIFO_DEPTH (4),
    .COLOUR_W   (CW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .flush      (flush),
    .flush_done (flush_done),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .clip_count (clip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write that will complete at the coming rising edge.
  always @(negedge clk) begin
    if (resetn && mem_we && mem_ready) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int x, input int y, input int c);
    int n = 0;
    in_x      = x[9:0];
    in_y      = y[8:0];
    in_colour = c[CW-1:0];
    in_valid  = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int comp_cyc;
    int done_cyc;
    int pulses;
    int n;

    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_colour = '0;
    flush     = 1'b0;
    mem_ready = 1'b0;

    // Reset state
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
    check("rst_mem_data", {29'd0, mem_data}, 32'd0);
    check("rst_flush_done", {31'd0, flush_done}, 32'd0);
    check("rst_clip_count", {24'd0, clip_count}, 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single point, latency and address 2*640+5
    mem_ready = 1'b1;
    send(5, 2, 3);
    check("single_we_latency", {31'd0, mem_we}, 32'd0);
    tick();
    check("single_we", {31'd0, mem_we}, 32'd1);
    check("single_addr", {13'd0, mem_addr}, 32'd1285);
    check("single_data", {29'd0, mem_data}, 32'd3);
    tick();
    check("single_we_drop", {31'd0, mem_we}, 32'd0);
    check("single_count", wa.size(), 32'd1);

    // Screen corners, back-to-back
    wa.delete();
    wd.delete();
    send(639, 479, 5);
    in_x = 10'd0; in_y = 9'd0; in_colour = 3'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("corner_hi_we", {31'd0, mem_we}, 32'd1);
    check("corner_hi_addr", {13'd0, mem_addr}, 32'd307199);
    check("corner_hi_data", {29'd0, mem_data}, 32'd5);
    tick();
    check("corner_b2b_we", {31'd0, mem_we}, 32'd1);
    check("corner_lo_addr", {13'd0, mem_addr}, 32'd0);
    check("corner_lo_data", {29'd0, mem_data}, 32'd2);
    tick();
    check("corner_we_drop", {31'd0, mem_we}, 32'd0);
    check("corner_count", wa.size(), 32'd2);

    // Backpressure: 4 buffered + 1 in flight, sixth point stalls
    wa.delete();
    wd.delete();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(10 + i, 20 + i, i + 1);
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    in_x = 10'd15; in_y = 9'd25; in_colour = 3'd6; in_valid = 1'b1;
    repeat (20) tick();
    check("bp_stall_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_we", {31'd0, mem_we}, 32'd1);
    check("bp_hold_addr", {13'd0, mem_addr}, 32'd12810);
    check("bp_no_writes", wa.size(), 32'd0);
    mem_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (wa.size() < 6 && n < 30) begin tick(); n++; end
    check("bp_write_count", wa.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < wa.size()) begin
        check($sformatf("bp_addr_%0d", i), {13'd0, wa[i]}, (20 + i) * 640 + 10 + i);
        check($sformatf("bp_data_%0d", i), {29'd0, wd[i]}, i + 1);
      end
    end
    tick();
    check("bp_idle_we", {31'd0, mem_we}, 32'd0);

    // Flush with writes outstanding, mem_ready high one cycle in three, flush held two cycles
    wa.delete();
    wd.delete();
    mem_ready = 1'b0;
    send(1, 1, 1);
    send(2, 1, 2);
    send(3, 1, 3);
    comp_cyc = -1;
    done_cyc = -1;
    pulses   = 0;
    for (int c = 0; c < 60; c++) begin
      flush     = (c < 2);
      mem_ready = (c % 3 == 2);
      if (mem_we && mem_ready && wa.size() == 2) comp_cyc = c;
      tick();
      if (flush_done) begin
        pulses++;
        done_cyc = c;
      end
    end
    flush = 1'b0;
    check("flush_pulses", pulses, 32'd1);
    check("flush_after_last", done_cyc, comp_cyc + 1);
    check("flush_writes", wa.size(), 32'd3);
    check("flush_last_addr", (wa.size() == 3) ? {13'd0, wa[2]} : 32'hFFFF_FFFF, 32'd643);

    // Flush with nothing outstanding
    mem_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("idle_flush_early", {31'd0, flush_done}, 32'd0);
    tick();
    check("idle_flush_done", {31'd0, flush_done}, 32'd1);
    tick();
    check("idle_flush_single", {31'd0, flush_done}, 32'd0);

    // Off-screen point
    wa.delete();
    wd.delete();
    send(700, 10, 1);
    repeat (3) tick();
`ifdef PLOT_CLIP_EN
    check("clip_no_write", wa.size(), 32'd0);
    check("clip_count_1", {24'd0, clip_count}, 32'd1);
    for (int i = 0; i < 299; i++) send(700, 10, 1);
    repeat (3) tick();
    check("clip_sat", {24'd0, clip_count}, 32'd255);
    check("clip_sat_no_write", wa.size(), 32'd0);
`else
    check("noclip_write", wa.size(), 32'd1);
    check("noclip_addr", (wa.size() == 1) ? {13'd0, wa[0]} : 32'hFFFF_FFFF, 32'd7100);
    check("noclip_count", {24'd0, clip_count}, 32'd0);
`endif

    // Reset during a write with three points queued
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(100 + i, 50, i + 2);
    check("mid_we_before", {31'd0, mem_we}, 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, mem_we}, 32'd0);
    check("mid_rst_addr", {13'd0, mem_addr}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_clip", {24'd0, clip_count}, 32'd0);
    wa.delete();
    wd.delete();
    tick();
    tick();
    resetn = 1'b1;
    #1;
    check("mid_rel_ready", {31'd0, in_ready}, 32'd1);
    mem_ready = 1'b1;
    repeat (6) tick();
    check("mid_no_stale", wa.size(), 32'd0);
    check("mid_idle_we", {31'd0, mem_we}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("mid_flush_done", {31'd0, flush_done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
